// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-consumer handshake bundle for decode_stage.
// master = the fetch/consumer side, slave = the decode stage itself.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      dec_opcode;
  logic [2:0]      dec_funct3;
  logic [4:0]      dec_rd;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [XLEN-1:0] dec_imm;
  logic [16:0]     dec_cu_info;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_pc;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, dec_opcode, dec_funct3, dec_rd, dec_rs1,
           dec_rs2, dec_imm, dec_cu_info, dec_illegal, dec_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, dec_opcode, dec_funct3, dec_rd, dec_rs1,
           dec_rs2, dec_imm, dec_cu_info, dec_illegal, dec_pc
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: combinational decode into a 2-entry
// output/skid buffer so in_ready never depends combinationally on out_ready.
module decode_stage #(
  parameter int XLEN          = 32,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [16:0]     cu_info;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  function automatic logic signed [XLEN-1:0] sext_imm(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        raw_ill_p0;
  entry_t      dec_p0;

  assign inst = bus.in_inst;
  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign f7   = inst[31:25];

  always_comb begin
    dec_p0        = '0;
    raw_ill_p0    = 1'b0;
    dec_p0.opcode = opc;
    dec_p0.pc     = bus.in_pc;
    case (opc)
      OPC_OP: begin
        dec_p0.rd      = inst[11:7];
        dec_p0.rs1     = inst[19:15];
        dec_p0.rs2     = inst[24:20];
        dec_p0.funct3  = f3;
        dec_p0.cu_info = {f7, f3, opc};
        raw_ill_p0     = !((f7 == 7'b0000000) ||
                           (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        dec_p0.rd      = inst[11:7];
        dec_p0.rs1     = inst[19:15];
        dec_p0.funct3  = f3;
        dec_p0.imm     = sext_imm({{20{inst[31]}}, inst[31:20]});
        dec_p0.cu_info = {7'b0, f3, opc};
        if (opc == OPC_JALR) begin
          raw_ill_p0 = (f3 != 3'b000);
        end else if (opc == OPC_LOAD) begin
          raw_ill_p0 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shift-immediates carry the arithmetic-shift selector in bit 30.
          dec_p0.cu_info = {f7 & 7'b0100000, f3, opc};
          raw_ill_p0     = (f3 == 3'b001) ? (f7 != 7'b0000000)
                                          : !(f7 == 7'b0000000 || f7 == 7'b0100000);
        end
      end
      OPC_STORE: begin
        dec_p0.rs1     = inst[19:15];
        dec_p0.rs2     = inst[24:20];
        dec_p0.funct3  = f3;
        dec_p0.imm     = sext_imm({{20{inst[31]}}, inst[31:25], inst[11:7]});
        dec_p0.cu_info = {7'b0, f3, opc};
        raw_ill_p0     = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec_p0.rs1     = inst[19:15];
        dec_p0.rs2     = inst[24:20];
        dec_p0.funct3  = f3;
        dec_p0.imm     = sext_imm({{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                   inst[11:8], 1'b0});
        dec_p0.cu_info = {7'b0, f3, opc};
        raw_ill_p0     = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_p0.rd      = inst[11:7];
        dec_p0.imm     = sext_imm({inst[31:12], 12'b0});
        dec_p0.cu_info = {10'b0, opc};
      end
      OPC_JAL: begin
        dec_p0.rd      = inst[11:7];
        dec_p0.imm     = sext_imm({{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                   inst[30:21], 1'b0});
        dec_p0.cu_info = {10'b0, opc};
      end
      OPC_SYSTEM: begin
        dec_p0.funct3  = f3;
        dec_p0.cu_info = {10'b0, opc};
      end
      default: raw_ill_p0 = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) raw_ill_p0 = 1'b1;
    // Illegal words keep only their PC so the trap path can report it.
    if (CHECK_ILLEGAL && raw_ill_p0) begin
      dec_p0         = '0;
      dec_p0.pc      = bus.in_pc;
      dec_p0.illegal = 1'b1;
    end
  end

  // ---- stage p1: output entry (O) and skid entry (S) ----
  entry_t out_p1;
  entry_t skid_p1;
  logic   vld_out_p1;
  logic   vld_skid_p1;
  logic   accept;
  logic   drain;

  assign accept = bus.in_valid && !vld_skid_p1;
  assign drain  = !vld_out_p1 || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out_p1  <= 1'b0;
      vld_skid_p1 <= 1'b0;
      out_p1      <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_out_p1  <= 1'b0;
      vld_skid_p1 <= 1'b0;
    end else if (drain) begin
      if (vld_skid_p1) begin
        out_p1      <= skid_p1;
        vld_out_p1  <= 1'b1;
        vld_skid_p1 <= 1'b0;
      end else begin
        vld_out_p1 <= accept;
        if (accept) out_p1 <= dec_p0;
      end
    end else if (accept) begin
      skid_p1     <= dec_p0;
      vld_skid_p1 <= 1'b1;
    end
  end

  assign bus.in_ready    = !vld_skid_p1;
  assign bus.out_valid   = vld_out_p1;
  assign bus.dec_opcode  = out_p1.opcode;
  assign bus.dec_funct3  = out_p1.funct3;
  assign bus.dec_rd      = out_p1.rd;
  assign bus.dec_rs1     = out_p1.rs1;
  assign bus.dec_rs2     = out_p1.rs2;
  assign bus.dec_imm     = out_p1.imm;
  assign bus.dec_cu_info = out_p1.cu_info;
  assign bus.dec_illegal = out_p1.illegal;
  assign bus.dec_pc      = out_p1.pc;

endmodule
